// File: rtl/sysid_info_regs_pkg.sv
// Shared constants for the system-ID register block: word addresses,
// CONTROL bit positions, block version and a byte-lane merge helper.
package sysid_info_regs_pkg;

    // Word addresses of the register map (addresses 8..15 are USER words)
    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_CONFIG    = 4'd2;
    localparam logic [3:0] ADDR_SCRATCH   = 4'd3;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] ADDR_CONTROL   = 4'd6;
    localparam logic [3:0] ADDR_RESERVED  = 4'd7;

    // CONTROL register bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // Block version reported in CONFIG[31:16]
    localparam logic [15:0] BLOCK_VERSION = 16'h0102;

    // Replace only the byte lanes of old_word whose enable bit is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sysid_info_regs_rd_pipe.sv
// Read-data delay line: carries a valid flag and its data word DEPTH
// cycles. Data is stored as zero when the stage is not valid, so the
// output word is zero whenever valid_o is low.
module sysid_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;

    // Shift valid/data one stage per clock; reset flushes reads in flight
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            // NOTE: the data stages are reset too (not only the valid bits) so
            // readdata is guaranteed zero after reset; the array is tiny.
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read the value
            // its predecessor held before this edge, giving a true shift.
            valid_q[0] <= valid_i;
            data_q[0]  <= valid_i ? data_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/sysid_info_regs.sv
// System identification register block: constant ID/timestamp/config and
// user words, a byte-writable scratch register, and a 64-bit uptime
// counter read through a LO-read-captures-HI snapshot.
module sysid_info_regs
    import sysid_info_regs_pkg::*;
#(
    parameter logic [31:0]       SYSTEM_ID       = 32'h0000_0000,
    parameter logic [31:0]       BUILD_TIMESTAMP = 32'h5AC2_7A80,
    parameter int                NUM_USER_WORDS  = 4,
    parameter logic [7:0][31:0]  USER_WORDS      = '0,
    parameter int                READ_LATENCY    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest
);

    localparam logic [31:0] CONFIG_WORD = {BLOCK_VERSION, 4'd0, 4'(READ_LATENCY),
                                           4'd0, 4'(NUM_USER_WORDS)};

    logic [31:0] scratch_q, scratch_d;
    logic [63:0] uptime_q,  uptime_d;
    logic [31:0] snap_q,    snap_d;
    logic        cnt_en_q,  cnt_en_d;
    logic        wr_accept;
    logic        ctrl_wr;
    logic [31:0] rd_word;

    // A write that coincides with a read is dropped; the read wins
    assign wr_accept = write & ~read;
    assign ctrl_wr   = wr_accept && (address == ADDR_CONTROL) && byteenable[0];

    // Next-state for scratch, counter enable, uptime counter and snapshot
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        scratch_d = scratch_q;
        cnt_en_d  = cnt_en_q;
        uptime_d  = uptime_q;
        snap_d    = snap_q;

        if (wr_accept && (address == ADDR_SCRATCH)) begin
            scratch_d = merge_bytes(scratch_q, writedata, byteenable);
        end

        if (ctrl_wr) begin
            cnt_en_d = writedata[CTRL_EN_BIT];
        end

        // Clear has priority over counting; the clear bit itself is not stored
        if (ctrl_wr && writedata[CTRL_CLR_BIT]) begin
            uptime_d = '0;
        end else if (cnt_en_q) begin
            uptime_d = uptime_q + 64'd1;
        end

        // Reading LO freezes the matching upper half for a later HI read
        if (read && (address == ADDR_UPTIME_LO)) begin
            snap_d = uptime_q[63:32];
        end
    end

    // Register state with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q <= '0;
            uptime_q  <= '0;
            snap_q    <= '0;
            cnt_en_q  <= 1'b1;
        end else begin
            scratch_q <= scratch_d;
            uptime_q  <= uptime_d;
            snap_q    <= snap_d;
            cnt_en_q  <= cnt_en_d;
        end
    end

    // Read multiplexer, sampled in the cycle the read is accepted
    always_comb begin
        rd_word = '0;
        if (address[3]) begin
            if (int'(address[2:0]) < NUM_USER_WORDS) begin
                rd_word = USER_WORDS[address[2:0]];
            end
        end else begin
            case (address)
                ADDR_ID:        rd_word = SYSTEM_ID;
                ADDR_TIMESTAMP: rd_word = BUILD_TIMESTAMP;
                ADDR_CONFIG:    rd_word = CONFIG_WORD;
                ADDR_SCRATCH:   rd_word = scratch_q;
                ADDR_UPTIME_LO: rd_word = uptime_q[31:0];
                ADDR_UPTIME_HI: rd_word = snap_q;
                ADDR_CONTROL:   rd_word = {31'd0, cnt_en_q};
                default:        rd_word = '0;
            endcase
        end
    end

    sysid_rd_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (32)
    ) u_rd_pipe (
        .clock_i (clock),
        .reset_i (reset),
        .valid_i (read),
        .data_i  (rd_word),
        .valid_o (readdatavalid),
        .data_o  (readdata)
    );

    assign waitrequest = 1'b0;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Self-checking bench for sysid_info_regs with READ_LATENCY=2 and two user
// words. Expected read data is queued when a read is issued and compared,
// together with its arrival cycle, when readdatavalid pulses.
module tb_sysid_info_regs;
    import sysid_info_regs_pkg::*;

    localparam int               LAT    = 2;
    localparam int               NUW    = 2;
    localparam logic [31:0]      SYS_ID = 32'h0000_1234;
    localparam logic [31:0]      TS     = 32'h5AC2_7A80;
    localparam logic [31:0]      CFG    = 32'h0102_0200 | 32'(NUW);
    localparam logic [7:0][31:0] USER   = {32'h8888_0007, 32'h7777_0006, 32'h6666_0005,
                                           32'h5555_0004, 32'h4444_0003, 32'h3333_0002,
                                           32'hBEEF_0001, 32'hCAFE_0000};

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model of the counter, snapshot and enable
    logic [63:0] m_cnt  = '0;
    logic [31:0] m_snap = '0;
    logic        m_en   = 1'b1;
    logic        load_req = 1'b0;
    logic [63:0] load_val = '0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    sysid_info_regs #(
        .SYSTEM_ID      (SYS_ID),
        .NUM_USER_WORDS (NUW),
        .USER_WORDS     (USER),
        .READ_LATENCY   (LAT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Counter model built from the register-map behaviour
    always @(posedge clock) begin
        if (reset) begin
            m_cnt  <= '0;
            m_snap <= '0;
            m_en   <= 1'b1;
        end else if (load_req) begin
            m_cnt <= load_val;
        end else begin
            if (read && address == ADDR_UPTIME_LO) m_snap <= m_cnt[63:32];
            if (write && !read && address == ADDR_CONTROL && byteenable[0]) begin
                m_en  <= writedata[0];
                m_cnt <= writedata[1] ? 64'd0 : (m_en ? m_cnt + 64'd1 : m_cnt);
            end else if (m_en) begin
                m_cnt <= m_cnt + 64'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        address = a;
        read    = 1'b1;
        write   = 1'b0;
        sb_q.push_back('{exp, cyc + LAT, name});
        @(posedge clock);
        #1;
        read = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        write      = 1'b1;
        writedata  = d;
        byteenable = be;
        @(posedge clock);
        #1;
        write = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle_cycle();
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (readdatavalid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_readdatavalid", 32'(readdatavalid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, readdata, e.data);
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("readdata_zero_when_idle", readdata, 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rst_exp [8];

        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; byteenable = '0;
        repeat (3) idle_cycle();
        check("reset_readdatavalid", 32'(readdatavalid), 32'd0);
        check("reset_readdata", readdata, 32'd0);
        check("waitrequest", 32'(waitrequest), 32'd0);
        reset = 1'b0;
        fork run_monitor(); join_none

        // Table of register accesses; the first read lands right after reset
        vecs.push_back('{1'b0, 4'd0,  32'h0,         4'h0, SYS_ID,        "id"});
        vecs.push_back('{1'b0, 4'd1,  32'h0,         4'h0, TS,            "timestamp"});
        vecs.push_back('{1'b0, 4'd2,  32'h0,         4'h0, CFG,           "config"});
        vecs.push_back('{1'b0, 4'd3,  32'h0,         4'h0, 32'h0,         "scratch_reset"});
        vecs.push_back('{1'b1, 4'd3,  32'hDEADBEEF,  4'h5, 32'h0,         ""});
        vecs.push_back('{1'b0, 4'd3,  32'h0,         4'h0, 32'h00AD00EF,  "scratch_be0101"});
        vecs.push_back('{1'b1, 4'd3,  32'h12345678,  4'hA, 32'h0,         ""});
        vecs.push_back('{1'b0, 4'd3,  32'h0,         4'h0, 32'h12AD56EF,  "scratch_be1010"});
        vecs.push_back('{1'b1, 4'd0,  32'hFFFFFFFF,  4'hF, 32'h0,         ""});
        vecs.push_back('{1'b0, 4'd0,  32'h0,         4'h0, SYS_ID,        "id_after_write"});
        vecs.push_back('{1'b1, 4'd8,  32'hFFFFFFFF,  4'hF, 32'h0,         ""});
        vecs.push_back('{1'b0, 4'd8,  32'h0,         4'h0, USER[0],       "user0_after_write"});
        vecs.push_back('{1'b1, 4'd7,  32'hFFFFFFFF,  4'hF, 32'h0,         ""});
        vecs.push_back('{1'b0, 4'd7,  32'h0,         4'h0, 32'h0,         "reserved"});
        vecs.push_back('{1'b0, 4'd5,  32'h0,         4'h0, 32'h0,         "snap_reset"});
        vecs.push_back('{1'b0, 4'd6,  32'h0,         4'h0, 32'h1,         "control_reset"});
        vecs.push_back('{1'b0, 4'd10, 32'h0,         4'h0, 32'h0,         "user2_absent"});
        vecs.push_back('{1'b0, 4'd15, 32'h0,         4'h0, 32'h0,         "user7_absent"});
        vecs.push_back('{1'b1, 4'd6,  32'hFFFFFFFD,  4'hF, 32'h0,         ""});
        vecs.push_back('{1'b0, 4'd6,  32'h0,         4'h0, 32'h1,         "control_upper_ignored"});
        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
            else            do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Read and write together: write dropped, read returns old scratch
        address = 4'd3; read = 1'b1; write = 1'b1;
        writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
        sb_q.push_back('{32'h12AD56EF, cyc + LAT, "rw_collision_read"});
        idle_cycle();
        read = 1'b0; write = 1'b0;
        do_read(4'd3, 32'h12AD56EF, "scratch_after_collision");

        // Four back-to-back reads must return in consecutive cycles
        do_read(4'd8,  USER[0], "b2b_user0");
        do_read(4'd9,  USER[1], "b2b_user1");
        do_read(4'd12, 32'h0,   "b2b_user4_absent");
        do_read(4'd7,  32'h0,   "b2b_reserved");
        drain();

        // Clear together with enable: counter restarts from zero
        do_write(4'd6, 32'h3, 4'hF);
        do_read(4'd4, m_cnt[31:0], "lo_right_after_clear");
        repeat (3) idle_cycle();
        do_read(4'd4, m_cnt[31:0], "lo_after_clear");
        do_read(4'd5, m_snap,      "hi_after_clear");
        do_read(4'd6, 32'h1,       "control_clear_bit_reads0");
        drain();

        // Low-word wrap into the upper half
        do_write(4'd6, 32'h0, 4'hF);
        force dut.uptime_q = 64'h0000_0000_FFFF_FFFF;
        load_val = 64'h0000_0000_FFFF_FFFF;
        load_req = 1'b1;
        idle_cycle();
        release dut.uptime_q;
        load_req = 1'b0;
        do_read(4'd4, m_cnt[31:0], "lo_before_wrap");
        do_read(4'd5, m_snap,      "hi_before_wrap");
        do_write(4'd6, 32'h1, 4'hF);
        repeat (2) idle_cycle();
        do_read(4'd4, m_cnt[31:0], "lo_after_wrap");
        do_read(4'd5, m_snap,      "hi_after_wrap");
        drain();

        // Reset one cycle after a read: the read must vanish
        address = 4'd0; read = 1'b1;
        idle_cycle();
        read = 1'b0; reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        rst_exp = '{SYS_ID, TS, CFG, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0};
        for (int a = 0; a < 8; a++) begin
            if (a == 4) do_read(4'(a), m_cnt[31:0], "post_reset_lo");
            else        do_read(4'(a), rst_exp[a], $sformatf("post_reset_word%0d", a));
        end
        drain();
        check("waitrequest_end", 32'(waitrequest), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysid_info_regs.md
SYSID_INFO_REGS -- requirements
Module: sysid_info_regs

Interface
REQ-001 Parameter SYSTEM_ID, default 32'h00000000, 32-bit system ID constant returned at word 0.
REQ-002 Parameter BUILD_TIMESTAMP, default 32'h5AC2_7A80, 32-bit build timestamp returned at word 1.
REQ-003 Parameter NUM_USER_WORDS, default 4, range 0..8: number of read-only user constant words.
REQ-004 Parameter USER_WORDS, default all zero, packed 8x32-bit array; word k is returned at address 8+k.
REQ-005 Parameter READ_LATENCY, default 1, range 1..2: cycles from accepted read to readdatavalid.
REQ-006 Port clock  input  1  single clock for all logic.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port address  input  4  word address.
REQ-009 Port read  input  1  read strobe.
REQ-010 Port write  input  1  write strobe.
REQ-011 Port writedata  input  32  write data.
REQ-012 Port byteenable  input  4  byte-lane enables for writes.
REQ-013 Port readdata  output  32  read data, valid when readdatavalid=1.
REQ-014 Port readdatavalid  output  1  one-cycle pulse marking readdata.
REQ-015 Port waitrequest  output  1  tied 0; every access is accepted in the cycle it is presented.

Function
REQ-016 Register map SHALL be: 0 ID (RO), 1 TIMESTAMP (RO), 2 CONFIG (RO), 3 SCRATCH (RW), 4 UPTIME_LO (RO), 5 UPTIME_HI_SNAP (RO), 6 CONTROL (RW), 7 reserved (reads 0), 8..15 USER.
REQ-017 CONFIG SHALL read {16'h0102 block version, 4'd0, READ_LATENCY[3:0], 4'd0, NUM_USER_WORDS[3:0]}.
REQ-018 SCRATCH SHALL update per byte lane where byteenable is set.
REQ-019 The uptime counter SHALL be 64 bits wide, SHALL increment by 1 each clock while CONTROL[0]=1, and SHALL wrap from all-ones to 0.
REQ-020 A read of UPTIME_LO SHALL return counter[31:0] and SHALL capture counter[63:32] from the same cycle into UPTIME_HI_SNAP.
REQ-021 A read of UPTIME_HI_SNAP SHALL return the captured value and SHALL leave the snapshot and counter unchanged.
REQ-022 CONTROL[0] SHALL be the RW counter enable; reset value 1.
REQ-023 Writing CONTROL[1]=1 SHALL clear the counter to 0 on the next clock edge; the bit SHALL be self-clearing and SHALL read 0.
REQ-024 If clear and enable coincide, clear SHALL win and the next counter value SHALL be 0.
REQ-025 CONTROL[31:2] SHALL read 0 and SHALL ignore writes.
REQ-026 Writes to RO or reserved addresses, and to USER addresses, SHALL be ignored without side effects.
REQ-027 Reads of USER addresses k >= NUM_USER_WORDS SHALL return 0.
REQ-028 Read data SHALL be sampled in the acceptance cycle and SHALL appear exactly READ_LATENCY cycles later, with readdatavalid=1 for one cycle.
REQ-029 Back-to-back reads on consecutive cycles SHALL each produce one readdatavalid pulse, in order, with no gaps.
REQ-030 If read and write assert in the same cycle, the write SHALL be ignored and the read SHALL proceed.
REQ-031 When readdatavalid=0, readdata SHALL be 0.

Reset
REQ-032 When reset=1 at a clock edge: counter=0, snapshot=0, SCRATCH=0, CONTROL[0]=1, all read pipeline stages cleared, readdatavalid=0, readdata=0.
REQ-033 Reads in flight at reset SHALL be discarded and SHALL produce no readdatavalid pulse.
REQ-034 A read accepted in the first cycle after reset deasserts SHALL be serviced normally.

Structure
REQ-035 A shared package SHALL define the register word-address constants, CONTROL bit indices, and the block version constant.
REQ-036 The read-latency pipeline SHALL be one sub-module, sysid_rd_pipe, parameterised by depth and data width.

Verification
REQ-037 Reset, then read addresses 0, 1, and 2 with SYSTEM_ID=32'h00001234 and READ_LATENCY=2 -> readdata 32'h00001234, 32'h5AC27A80, and 32'h01020200|NUM_USER_WORDS, each 2 cycles after its read.
REQ-038 Write SCRATCH 32'hDEADBEEF with byteenable=4'b0101 after reset -> reading SCRATCH returns 32'h00AD00EF.
REQ-039 Force the counter to 64'h0000_0000_FFFF_FFFF, read UPTIME_LO, then UPTIME_HI_SNAP -> results 32'hFFFFFFFF and 32'h0; a second read pair returns a LO value that has wrapped and HI_SNAP=1.
REQ-040 Write CONTROL=32'h3 -> the counter is 0 on the next cycle; a UPTIME_LO read 5 cycles later returns a value 4 or 5 cycles' worth of counting (exact value per implementation-defined capture cycle, checked against the model); CONTROL reads 32'h1.
REQ-041 Issue 4 back-to-back reads (addresses 8, 9, 12, 7) with NUM_USER_WORDS=2 -> 4 consecutive valid pulses with data USER[0], USER[1], 0, 0.
REQ-042 Assert reset one cycle after a read with READ_LATENCY=2 -> no readdatavalid pulse appears, and all registers read back their reset values.
